// File: rtl/core_dispatch_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : core_dispatch_scoreboard_pkg
//  Purpose  : Shared micro-architecture types and sizes for the dispatch
//             scoreboard (EU indices, register numbers, counter width).
//  Revision : 1.0 - initial release
// ============================================================================
package core_dispatch_scoreboard_pkg;

    localparam int NUM_REGS = 16;   // architectural registers, one hword bit each
    localparam int NUM_EU   = 5;    // execution units tracked
    localparam int CNT_W    = 2;    // in-flight counter width per (EU, register)
    localparam int RD_W     = 4;    // register number width
    localparam int EU_W     = 3;    // EU index width (leaves room for out-of-range codes)

    typedef logic [NUM_REGS-1:0] hword;
    typedef logic [RD_W-1:0]     reg_num;

    typedef enum logic [EU_W-1:0] {
        EU_ALU_A  = 3'd0,
        EU_ALU_B  = 3'd1,
        EU_BRANCH = 3'd2,
        EU_LDST   = 3'd3,
        EU_MUL    = 3'd4
    } eu_idx;

endpackage : core_dispatch_scoreboard_pkg
`default_nettype wire

// File: rtl/core_dispatch_scoreboard_if.sv
`default_nettype none
// ============================================================================
//  Module   : core_dispatch_scoreboard_if
//  Purpose  : Dispatch (set), writeback (clear) and pending-mask bundle
//             between the pipeline and the register scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
interface core_dispatch_scoreboard_if;
    import core_dispatch_scoreboard_pkg::*;

    // Dispatch side: two slots per cycle
    logic                     flush;
    logic                     dispatch_a;
    logic                     a_writeback;
    reg_num                   a_rd;
    logic [EU_W-1:0]          a_eu;
    logic                     dispatch_b;
    logic                     b_writeback;
    reg_num                   b_rd;
    logic [EU_W-1:0]          b_eu;

    // Writeback side: one retiring register per EU
    logic [NUM_EU-1:0]        wb_valid;
    logic [NUM_EU*RD_W-1:0]   wb_rd;

    // Pending-write masks toward the hazard check
    hword                     mask_alu_a;
    hword                     mask_alu_b;
    hword                     mask_branch;
    hword                     mask_ldst;
    hword                     mask_mul;
    logic                     busy;
    logic                     sb_error;

    // Pipeline side: drives events, observes masks
    modport master (
        output flush, dispatch_a, a_writeback, a_rd, a_eu,
               dispatch_b, b_writeback, b_rd, b_eu, wb_valid, wb_rd,
        input  mask_alu_a, mask_alu_b, mask_branch, mask_ldst, mask_mul,
               busy, sb_error
    );

    // Scoreboard side
    modport slave (
        input  flush, dispatch_a, a_writeback, a_rd, a_eu,
               dispatch_b, b_writeback, b_rd, b_eu, wb_valid, wb_rd,
        output mask_alu_a, mask_alu_b, mask_branch, mask_ldst, mask_mul,
               busy, sb_error
    );

endinterface : core_dispatch_scoreboard_if
`default_nettype wire

// File: rtl/core_dispatch_scoreboard_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : core_dispatch_scoreboard_cnt
//  Purpose  : One saturating in-flight write counter. Adds 0..2 and
//             subtracts 0..1 per cycle; clr wins over both. Reports
//             whether the next count is nonzero and whether this cycle
//             over- or underflowed.
//  Revision : 1.0 - initial release
// ============================================================================
module core_dispatch_scoreboard_cnt #(
    parameter int CNT_W = 2
) (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic [1:0] inc_i,
    input  wire logic       dec_i,
    input  wire logic       clr_i,
    output logic            nonzero_o,
    output logic            err_o
);

    // Two spare bits hold cnt + 2 without wrapping
    localparam int               SUM_W = CNT_W + 2;
    localparam logic [SUM_W-1:0] C_MAX = SUM_W'((1 << CNT_W) - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [SUM_W-1:0] sum;

    // Net update: increments are applied before the decrement so that a
    // set and clear on an empty counter nets to zero without an underflow.
    always_comb begin
        cnt_d = cnt_q;
        err_o = 1'b0;
        sum   = SUM_W'(cnt_q) + SUM_W'(inc_i);
        if (clr_i) begin
            cnt_d = '0;
        end else begin
            if (dec_i) begin
                if (sum == '0) begin
                    err_o = 1'b1;
                end else begin
                    sum = sum - SUM_W'(1);
                end
            end
            if (sum > C_MAX) begin
                cnt_d = C_MAX[CNT_W-1:0];
                err_o = 1'b1;
            end else begin
                cnt_d = sum[CNT_W-1:0];
            end
        end
        nonzero_o = (cnt_d != '0);
    end

    // Counter state register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : core_dispatch_scoreboard_cnt
`default_nettype wire

// File: rtl/core_dispatch_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : core_dispatch_scoreboard
//  Purpose  : Producer-side register scoreboard. Counts in-flight writes per
//             (EU, register), exports one registered pending mask per EU,
//             a busy flag and a sticky error flag.
//  Revision : 1.0 - initial release
// ============================================================================
module core_dispatch_scoreboard
    import core_dispatch_scoreboard_pkg::*;
(
    input  wire logic                 clk,
    input  wire logic                 rst,
    core_dispatch_scoreboard_if.slave sb
);

    logic                             set_a;
    logic                             set_b;
    logic                             eu_err;
    logic [NUM_EU-1:0][NUM_REGS-1:0]  nz_next;
    logic [NUM_EU-1:0][NUM_REGS-1:0]  cnt_err;
    logic [NUM_EU-1:0][NUM_REGS-1:0]  mask_q;
    logic                             busy_q;
    logic                             err_q;

    // A slot only produces a hazard when it actually writes rd
    assign set_a  = sb.dispatch_a & sb.a_writeback;
    assign set_b  = sb.dispatch_b & sb.b_writeback;
    assign eu_err = (set_a && (sb.a_eu >= EU_W'(NUM_EU))) ||
                    (set_b && (sb.b_eu >= EU_W'(NUM_EU)));

    generate
        for (genvar e = 0; e < NUM_EU; e++) begin : g_eu
            reg_num wb_rd_e;
            assign wb_rd_e = sb.wb_rd[e*RD_W +: RD_W];

            for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
                logic       hit_a;
                logic       hit_b;
                logic [1:0] inc;
                logic       dec;

                assign hit_a = set_a && (sb.a_eu == EU_W'(e)) && (sb.a_rd == RD_W'(r));
                assign hit_b = set_b && (sb.b_eu == EU_W'(e)) && (sb.b_rd == RD_W'(r));
                assign inc   = {1'b0, hit_a} + {1'b0, hit_b};
                assign dec   = sb.wb_valid[e] && (wb_rd_e == RD_W'(r));

                core_dispatch_scoreboard_cnt #(
                    .CNT_W (CNT_W)
                ) u_cnt (
                    .clk       (clk),
                    .rst       (rst),
                    .inc_i     (inc),
                    .dec_i     (dec),
                    .clr_i     (sb.flush),
                    .nonzero_o (nz_next[e][r]),
                    .err_o     (cnt_err[e][r])
                );
            end
        end
    endgenerate

    // Output registers track the counters' next state, so masks and busy
    // line up with the counters; the error flag is sticky until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q <= '0;
            busy_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            mask_q <= nz_next;
            busy_q <= |nz_next;
            err_q  <= err_q | (|cnt_err) | eu_err;
        end
    end

    assign sb.mask_alu_a  = mask_q[EU_ALU_A];
    assign sb.mask_alu_b  = mask_q[EU_ALU_B];
    assign sb.mask_branch = mask_q[EU_BRANCH];
    assign sb.mask_ldst   = mask_q[EU_LDST];
    assign sb.mask_mul    = mask_q[EU_MUL];
    assign sb.busy        = busy_q;
    assign sb.sb_error    = err_q;

endmodule : core_dispatch_scoreboard
`default_nettype wire

// File: tb/tb_core_dispatch_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : tb_core_dispatch_scoreboard
//  Purpose  : Directed, table-driven bench for the dispatch scoreboard. Each
//             row is one cycle of stimulus plus the outputs expected right
//             after that cycle's clock edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_core_dispatch_scoreboard;

    typedef struct {
        bit          rst;
        bit          flush;
        bit          da;
        bit          aw;
        logic [3:0]  ard;
        logic [2:0]  aeu;
        bit          db;
        bit          bw;
        logic [3:0]  brd;
        logic [2:0]  beu;
        logic [4:0]  wbv;
        logic [19:0] wbrd;
        logic [79:0] exp_mask;   // {alu_a, alu_b, branch, ldst, mul}
        bit          exp_busy;
        bit          exp_err;
    } vec_t;

    localparam logic [15:0] Z = 16'h0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;
    vec_t tbl[$];

    core_dispatch_scoreboard_if sbif ();

    core_dispatch_scoreboard dut (
        .clk (clk),
        .rst (rst),
        .sb  (sbif.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] wbf(input int e, input logic [3:0] rd);
        logic [19:0] x;
        x = '0;
        x[e*4 +: 4] = rd;
        return x;
    endfunction

    function automatic vec_t row(
        input bit r, input bit f,
        input bit da, input bit aw, input logic [3:0] ard, input logic [2:0] aeu,
        input bit db, input bit bw, input logic [3:0] brd, input logic [2:0] beu,
        input logic [4:0] wbv, input logic [19:0] wbrd,
        input logic [15:0] ma, input logic [15:0] mb, input logic [15:0] mbr,
        input logic [15:0] mld, input logic [15:0] mmul,
        input bit busy, input bit err);
        vec_t v;
        v.rst = r;   v.flush = f;
        v.da  = da;  v.aw = aw; v.ard = ard; v.aeu = aeu;
        v.db  = db;  v.bw = bw; v.brd = brd; v.beu = beu;
        v.wbv = wbv; v.wbrd = wbrd;
        v.exp_mask = {ma, mb, mbr, mld, mmul};
        v.exp_busy = busy;
        v.exp_err  = err;
        return v;
    endfunction

    // Idle cycle with given expected outputs
    function automatic vec_t idle(input logic [15:0] ma, input logic [15:0] mb,
                                  input logic [15:0] mbr, input logic [15:0] mld,
                                  input logic [15:0] mmul, input bit busy, input bit err);
        return row(0,0, 0,0,4'd0,3'd0, 0,0,4'd0,3'd0, 5'b0,20'h0, ma,mb,mbr,mld,mmul, busy,err);
    endfunction

    task automatic apply(input vec_t v, input int idx);
        logic [79:0] got;
        rst              = v.rst;
        sbif.flush       = v.flush;
        sbif.dispatch_a  = v.da;
        sbif.a_writeback = v.aw;
        sbif.a_rd        = v.ard;
        sbif.a_eu        = v.aeu;
        sbif.dispatch_b  = v.db;
        sbif.b_writeback = v.bw;
        sbif.b_rd        = v.brd;
        sbif.b_eu        = v.beu;
        sbif.wb_valid    = v.wbv;
        sbif.wb_rd       = v.wbrd;
        @(posedge clk);
        #1;
        got = {sbif.mask_alu_a, sbif.mask_alu_b, sbif.mask_branch,
               sbif.mask_ldst, sbif.mask_mul};
        n_checks++;
        if (got === v.exp_mask) n_pass++;
        else $display("FAIL step%0d masks: got %h expected %h", idx, got, v.exp_mask);
        n_checks++;
        if (sbif.busy === v.exp_busy) n_pass++;
        else $display("FAIL step%0d busy: got %b expected %b", idx, sbif.busy, v.exp_busy);
        n_checks++;
        if (sbif.sb_error === v.exp_err) n_pass++;
        else $display("FAIL step%0d sb_error: got %b expected %b", idx, sbif.sb_error, v.exp_err);
    endtask

    initial begin
        sbif.flush = 1'b0; sbif.dispatch_a = 1'b0; sbif.a_writeback = 1'b0;
        sbif.a_rd = '0; sbif.a_eu = '0; sbif.dispatch_b = 1'b0;
        sbif.b_writeback = 1'b0; sbif.b_rd = '0; sbif.b_eu = '0;
        sbif.wb_valid = '0; sbif.wb_rd = '0;

        // Reset, then 5 idle cycles
        tbl.push_back(row(1,0, 0,0,4'd0,3'd0, 0,0,4'd0,3'd0, 5'b0,20'h0, Z,Z,Z,Z,Z, 0,0));
        for (int i = 0; i < 5; i++) tbl.push_back(idle(Z,Z,Z,Z,Z, 0,0));
        // Dispatch without writeback is ignored
        tbl.push_back(row(0,0, 0,0,4'd0,3'd0, 1,0,4'd4,3'd0, 5'b0,20'h0, Z,Z,Z,Z,Z, 0,0));
        // ALU_A rd3: set, held two cycles, retired
        tbl.push_back(row(0,0, 1,1,4'd3,3'd0, 0,0,4'd0,3'd0, 5'b0,20'h0, 16'h0008,Z,Z,Z,Z, 1,0));
        tbl.push_back(idle(16'h0008,Z,Z,Z,Z, 1,0));
        tbl.push_back(idle(16'h0008,Z,Z,Z,Z, 1,0));
        tbl.push_back(row(0,0, 0,0,4'd0,3'd0, 0,0,4'd0,3'd0, 5'b00001,wbf(0,4'd3), Z,Z,Z,Z,Z, 0,0));
        // A and B both to ALU_B rd5 (count 2), two retirements needed
        tbl.push_back(row(0,0, 1,1,4'd5,3'd1, 1,1,4'd5,3'd1, 5'b0,20'h0, Z,16'h0020,Z,Z,Z, 1,0));
        tbl.push_back(idle(Z,16'h0020,Z,Z,Z, 1,0));
        tbl.push_back(row(0,0, 0,0,4'd0,3'd0, 0,0,4'd0,3'd0, 5'b00010,wbf(1,4'd5), Z,16'h0020,Z,Z,Z, 1,0));
        tbl.push_back(idle(Z,16'h0020,Z,Z,Z, 1,0));
        tbl.push_back(row(0,0, 0,0,4'd0,3'd0, 0,0,4'd0,3'd0, 5'b00010,wbf(1,4'd5), Z,Z,Z,Z,Z, 0,0));
        // MUL rd7 at 1; same-cycle set+clear keeps it at 1
        tbl.push_back(row(0,0, 1,1,4'd7,3'd4, 0,0,4'd0,3'd0, 5'b0,20'h0, Z,Z,Z,Z,16'h0080, 1,0));
        tbl.push_back(row(0,0, 0,0,4'd0,3'd0, 1,1,4'd7,3'd4, 5'b10000,wbf(4,4'd7), Z,Z,Z,Z,16'h0080, 1,0));
        tbl.push_back(idle(Z,Z,Z,Z,16'h0080, 1,0));
        tbl.push_back(row(0,0, 0,0,4'd0,3'd0, 0,0,4'd0,3'd0, 5'b10000,wbf(4,4'd7), Z,Z,Z,Z,Z, 0,0));
        // LDST rd1 + BRANCH rd14 pending, then flush beats a new dispatch
        tbl.push_back(row(0,0, 1,1,4'd1,3'd3, 1,1,4'd14,3'd2, 5'b0,20'h0, Z,Z,16'h4000,16'h0002,Z, 1,0));
        tbl.push_back(row(0,1, 1,1,4'd2,3'd0, 0,0,4'd0,3'd0, 5'b0,20'h0, Z,Z,Z,Z,Z, 0,0));
        tbl.push_back(idle(Z,Z,Z,Z,Z, 0,0));
        // Flush also suppresses a clear on an empty counter
        tbl.push_back(row(0,1, 0,0,4'd0,3'd0, 0,0,4'd0,3'd0, 5'b00001,wbf(0,4'd9), Z,Z,Z,Z,Z, 0,0));
        // Underflow: sticky through flush and idle, cleared by reset
        tbl.push_back(row(0,0, 0,0,4'd0,3'd0, 0,0,4'd0,3'd0, 5'b00001,wbf(0,4'd9), Z,Z,Z,Z,Z, 0,1));
        tbl.push_back(row(0,1, 0,0,4'd0,3'd0, 0,0,4'd0,3'd0, 5'b0,20'h0, Z,Z,Z,Z,Z, 0,1));
        tbl.push_back(idle(Z,Z,Z,Z,Z, 0,1));
        tbl.push_back(row(1,0, 0,0,4'd0,3'd0, 0,0,4'd0,3'd0, 5'b0,20'h0, Z,Z,Z,Z,Z, 0,0));
        // Saturation on BRANCH rd6: 2, 3, then +2 saturates at 3 with error
        tbl.push_back(row(0,0, 1,1,4'd6,3'd2, 1,1,4'd6,3'd2, 5'b0,20'h0, Z,Z,16'h0040,Z,Z, 1,0));
        tbl.push_back(row(0,0, 1,1,4'd6,3'd2, 0,0,4'd0,3'd0, 5'b0,20'h0, Z,Z,16'h0040,Z,Z, 1,0));
        tbl.push_back(row(0,0, 1,1,4'd6,3'd2, 1,1,4'd6,3'd2, 5'b0,20'h0, Z,Z,16'h0040,Z,Z, 1,1));
        tbl.push_back(row(0,0, 0,0,4'd0,3'd0, 0,0,4'd0,3'd0, 5'b00100,wbf(2,4'd6), Z,Z,16'h0040,Z,Z, 1,1));
        tbl.push_back(row(0,0, 0,0,4'd0,3'd0, 0,0,4'd0,3'd0, 5'b00100,wbf(2,4'd6), Z,Z,16'h0040,Z,Z, 1,1));
        tbl.push_back(row(0,0, 0,0,4'd0,3'd0, 0,0,4'd0,3'd0, 5'b00100,wbf(2,4'd6), Z,Z,Z,Z,Z, 0,1));
        tbl.push_back(row(1,0, 0,0,4'd0,3'd0, 0,0,4'd0,3'd0, 5'b0,20'h0, Z,Z,Z,Z,Z, 0,0));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

        // Hand sequence: out-of-range EU on slot B sets the error, no mask
        apply(row(0,0, 0,0,4'd0,3'd0, 1,1,4'd0,3'd5, 5'b0,20'h0, Z,Z,Z,Z,Z, 0,1), 100);
        apply(idle(Z,Z,Z,Z,Z, 0,1), 101);
        apply(row(1,0, 0,0,4'd0,3'd0, 0,0,4'd0,3'd0, 5'b0,20'h0, Z,Z,Z,Z,Z, 0,0), 102);

        // Hand sequence: reset mid-operation beats flush and a dispatch
        apply(row(0,0, 1,1,4'd9,3'd3, 0,0,4'd0,3'd0, 5'b0,20'h0, Z,Z,Z,16'h0200,Z, 1,0), 110);
        apply(row(1,1, 1,1,4'd10,3'd3, 0,0,4'd0,3'd0, 5'b0,20'h0, Z,Z,Z,Z,Z, 0,0), 111);
        apply(idle(Z,Z,Z,Z,Z, 0,0), 112);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_core_dispatch_scoreboard
`default_nettype wire

// File: doc/core_dispatch_scoreboard.md
Name: core_dispatch_scoreboard

Overview:
- Register scoreboard on the producer side of the dispatch hazard check.
- Records the destination register of each dispatched, writing instruction against the execution unit (EU) it was issued to. Releases the register when that EU's writeback retires it.
- Exports one pending-write mask per EU, which the dispatch hazard logic ORs and tests against source-register masks.
- Sits between the dispatch stage (set side) and the writeback stage (clear side).

Parameters:
- NUM_REGS, 16, architectural registers tracked; equals hword width.
- NUM_EU, 5, EUs tracked: ALU_A=0, ALU_B=1, BRANCH=2, LDST=3, MUL=4.
- CNT_W, 2, width of each per-EU per-register in-flight counter.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- flush  in  1  pipeline flush; all EUs are flushed in the same cycle
- dispatch_a  in  1  slot A dispatched this cycle
- a_writeback  in  1  slot A instruction writes rd
- a_rd  in  4  slot A destination register
- a_eu  in  3  slot A target EU index
- dispatch_b, b_writeback, b_rd, b_eu  in  1/1/4/3  same fields for slot B
- wb_valid  in  NUM_EU  per-EU writeback retiring a register this cycle
- wb_rd  in  NUM_EU*4  per-EU retired register number
- mask_alu_a, mask_alu_b, mask_branch, mask_ldst, mask_mul  out  16 each  bit r = EU has at least one write to r in flight
- busy  out  1  any counter nonzero
- sb_error  out  1  sticky; counter overflow or underflow occurred

Behaviour:
- State is one CNT_W-bit counter per (EU, register): NUM_EU*NUM_REGS counters. Mask bit = counter != 0.
- All outputs are registered and reflect counter state at the start of the cycle.
  - A dispatch in cycle t shows in the masks from t+1.
  - A writeback in cycle t clears the bit from t+1.
- Reset: all counters 0, every mask 0, busy 0, sb_error 0.
- Set event: dispatch_x && x_writeback increments counter[x_eu][x_rd].
  - Dispatch without writeback, or x_eu >= NUM_EU, is ignored. An out-of-range x_eu also sets sb_error.
- Clear event: wb_valid[e] decrements counter[e][wb_rd[e]].
- Per-counter net update each cycle = (A set hit) + (B set hit) − (clear hit), range −1..+2.
  - A and B targeting the same EU and rd in one cycle give +2. The dispatch hazard check does not block WAW.
  - Set and clear on the same counter in one cycle: net 0, bit stays set, no glitch.
- Overflow: a result above 2^CNT_W−1 saturates at max and sets sb_error.
- Underflow: a decrement at 0 leaves the counter at 0 and sets sb_error.
- Flush: all counters go to 0 next cycle. Flush overrides same-cycle set and clear events. sb_error is not cleared by flush.
- Reset mid-operation: rst overrides flush and all events; state returns to the reset values above.
- sb_error clears only on rst.
- busy = OR of all masks, registered with them.

Decomposition:
- Shared uarch package:
  - eu_idx enum (EU_ALU_A..EU_MUL), NUM_EU
  - reg_num typedef (4-bit); hword is already there
- Sub-module core_dispatch_scoreboard_cnt: one saturating up/down counter.
  - Inputs: inc count 0..2, dec, clr.
  - Outputs: nonzero, err.
- Top level instantiates the counter NUM_EU*NUM_REGS times, decodes set/clear hits, and registers the masks.

Test Plan:
- Reset then idle 5 cycles -> all masks 0x0000, busy 0, sb_error 0.
- dispatch_a, a_writeback=1, a_rd=3, a_eu=ALU_A at t0; wb_valid[ALU_A], wb_rd=3 at t3 -> mask_alu_a=0x0008 during t1..t3, 0x0000 at t4.
- Same cycle: A to ALU_B rd=5, B to ALU_B rd=5. One writeback of rd=5 at t2, a second at t4 -> mask_alu_b=0x0020 through t4, 0x0000 at t5; no sb_error.
- Counter for MUL rd=7 at 1; in one cycle dispatch_b to MUL rd=7 plus wb_valid[MUL] rd=7 -> mask_mul stays 0x0080 every cycle; counter unchanged at 1.
- Pending bits in LDST (rd 1) and BRANCH (rd 14); flush together with a new dispatch to ALU_A rd=2 -> next cycle all masks 0, busy 0.
- wb_valid[ALU_A] rd=9 with its counter at 0 -> sb_error=1 next cycle, stays 1 through a flush, clears only on rst.
